aes_inv_cipher: RTL and testbench
=================================

Name: aes_inv_cipher

Overview:
Iterative AES-128 inverse cipher (decryptor), the counterpart of the `aes` encryption core.
- Accepts a ciphertext block and the round-10 key, i.e. the `key_out` of the encryptor.
- Computes one inverse round per clock, deriving earlier round keys on the fly with the inverse key schedule.
- Returns the plaintext and the recovered original cipher key.
- Sits beside `aes` in the crypto datapath; the same byte/column layout allows direct loopback.

Parameters:
- none: AES-128 only, Nr fixed at 10, Rcon and S-box/inverse S-box are internal constants.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous active-low reset (rst=0 resets immediately)
- en  input  1  start request, sampled on rising edge while busy=0
- state  input  128  ciphertext block
- key  input  128  round-10 (final) round key
- busy  output  1  operation in progress
- done  output  1  result valid, level
- state_out  output  128  plaintext
- key_out  output  128  recovered round-0 (cipher) key

Behaviour:
- Byte layout (both directions): byte i = bits [8i+:8].
  - Column c = bytes 4c..4c+3; row r of column c = byte 4c+r.
  - Round-key word c = column c, with row 0 in the low byte.
- Reset (rst=0, async): FSM -> IDLE; busy=0, done=0, state_out=0, key_out=0; internal state, key and counter cleared. Reset mid-operation aborts with no partial result.
- FSM states:
  - IDLE: on en=1 at an edge:
    - s <= state ^ key; k <= key; rnd <= 10
    - busy <= 1, done <= 0 -> RUN
    - en=0: hold.
  - RUN: each edge:
    - k' = InvKeyStep(k, Rcon[rnd])
    - s <= InvShiftRows -> InvSubBytes -> AddRoundKey(k') -> InvMixColumns; InvMixColumns omitted when rnd==1
    - k <= k'; rnd <= rnd-1
  - RUN, on the edge with rnd==1: state_out <= final s, key_out <= k', done <= 1, busy <= 0 -> IDLE.
- Latency: en accepted at edge E0 -> done=1 and outputs valid after edge E10 (10 cycles).
- InvKeyStep(w0..w3, rc), using new words p0..p3:
  - p3 = w3^w2; p2 = w2^w1; p1 = w1^w0
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ {24'h0, rc}
  - RotWord moves row1 into row0.
  - Rcon for rnd 10..1 = 36,1b,80,40,20,10,08,04,02,01.
- InvShiftRows: row r rotates right by r columns, i.e. new column c row r = old column (c-r) mod 4, row r.
- InvMixColumns: GF(2^8) with polynomial 0x11b; matrix rows {0e,0b,0d,09} rotated per row.
- en while busy=1: ignored; inputs are not re-sampled and the operation continues unchanged.
- done: stays 1, and state_out/key_out hold, until the next accepted en. Then done drops to 0 at E0; the old outputs stay until the new completion.
- en held high continuously: a new operation is accepted on the first edge after completion, giving one operation every 11 cycles.
- Inputs `state`/`key` need only be stable at the accepting edge.

Test Plan:
1. FIPS-197 C.1: state=128'h5ac5b47080b7cdd830047b6ad8e0c469, key=128'hc5302b4d8ba707f3174a94e37f1d1113, en pulse -> after 10 cycles done=1, state_out=128'hffeeddccbbaa99887766554433221100, key_out=128'h0f0e0d0c0b0a09080706050403020100.
2. FIPS-197 App. B: state=128'h320b6a19978511dcfb09dc021d842539, key=128'ha60c63b6c80c3fe18925eec9a8f914d0 -> state_out=128'h340737e0a29831318d305a88a8f64332, key_out=128'h3c4fcf098815f7aba6d2ae2816157e2b, exactly 10 cycles after accept.
3. Start vector 1, then at cycle 4 pulse en with vector 2's inputs -> ignored; vector 1 result at cycle 10, busy never drops early.
4. Start vector 1, drive rst=0 mid-cycle at cycle 5 -> immediately busy=0, done=0, outputs 0. Release, run vector 2 -> correct vector-2 result.
5. Hold en=1 with vector 1 -> done rises at cycles 10, 21, 32; done low for exactly 10 cycles between completions; each result correct.
6. Loopback: encrypt 128'hff6ec9c370a6678992b1fb90f3fd6595 with key 128'h01010101010101010101010101010101 on `aes`, feed its state_out/key_out into this block -> original plaintext and key recovered.

Source files
------------

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 inverse cipher: one inverse round per clock, with earlier
// round keys rewound on the fly from the final (round-10) key.
module aes_inv_cipher (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [127:0] state,
    input  logic [127:0] key,
    output logic         busy,
    output logic         done,
    output logic [127:0] state_out,
    output logic [127:0] key_out
);

    typedef enum logic {IDLE, RUN} fsm_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd10:   return 8'h36;
            4'd9:    return 8'h1b;
            4'd8:    return 8'h80;
            4'd7:    return 8'h40;
            4'd6:    return 8'h20;
            4'd5:    return 8'h10;
            4'd4:    return 8'h08;
            4'd3:    return 8'h04;
            4'd2:    return 8'h02;
            4'd1:    return 8'h01;
            default: return 8'h00;
        endcase
    endfunction

    // Matrix {0e,0b,0d,09} built from doubling chains of each input byte.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0]  a, x2, x4, x8;
        logic [7:0]  m9 [4];
        logic [7:0]  mb [4];
        logic [7:0]  md [4];
        logic [7:0]  me [4];
        logic [31:0] res;
        for (int r = 0; r < 4; r++) begin
            a     = col[8*r +: 8];
            x2    = xtime(a);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[r] = x8 ^ a;
            mb[r] = x8 ^ x2 ^ a;
            md[r] = x8 ^ x4 ^ a;
            me[r] = x8 ^ x4 ^ x2;
        end
        res = '0;
        for (int r = 0; r < 4; r++)
            res[8*r +: 8] = me[r] ^ mb[(r+1) & 3] ^ md[(r+2) & 3] ^ m9[(r+3) & 3];
        return res;
    endfunction

    // Undo one forward key-expansion step: recover round key r-1 from round key r.
    function automatic logic [127:0] inv_key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, p3, rot, sub;
        w0  = k[31:0];
        w1  = k[63:32];
        w2  = k[95:64];
        p3  = k[127:96] ^ w2;
        rot = {p3[7:0], p3[31:8]};
        for (int i = 0; i < 4; i++)
            sub[8*i +: 8] = SBOX[rot[8*i +: 8]];
        return {p3, w2 ^ w1, w1 ^ w0, w0 ^ sub ^ {24'h0, rc}};
    endfunction

    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [127:0] t;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[8*(4*c+r) +: 8] = INV_SBOX[s[8*(4*((c-r) & 3)+r) +: 8]];
        t = t ^ rk;
        if (!last)
            for (int c = 0; c < 4; c++)
                t[32*c +: 32] = inv_mix_col(t[32*c +: 32]);
        return t;
    endfunction

    fsm_t         fsm_q, fsm_d;
    logic [127:0] s_q, s_d, k_q, k_d;
    logic [3:0]   rnd_q, rnd_d;
    logic         busy_q, busy_d, done_q, done_d;
    logic [127:0] pt_q, pt_d, ck_q, ck_d;
    logic [127:0] k_prev, round_out;

    // Next-state and datapath; the round logic runs every cycle but only commits in RUN.
    always_comb begin
        fsm_d     = fsm_q;
        s_d       = s_q;
        k_d       = k_q;
        rnd_d     = rnd_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pt_d      = pt_q;
        ck_d      = ck_q;
        k_prev    = inv_key_step(k_q, rcon(rnd_q));
        round_out = inv_round(s_q, k_prev, rnd_q == 4'd1);
        case (fsm_q)
            IDLE: begin
                if (en) begin
                    s_d    = state ^ key;
                    k_d    = key;
                    rnd_d  = 4'd10;
                    busy_d = 1'b1;
                    done_d = 1'b0;
                    fsm_d  = RUN;
                end
            end
            RUN: begin
                s_d   = round_out;
                k_d   = k_prev;
                rnd_d = rnd_q - 4'd1;
                if (rnd_q == 4'd1) begin
                    pt_d   = round_out;
                    ck_d   = k_prev;
                    done_d = 1'b1;
                    busy_d = 1'b0;
                    fsm_d  = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q  <= IDLE;
            s_q    <= '0;
            k_q    <= '0;
            rnd_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pt_q   <= '0;
            ck_q   <= '0;
        end else begin
            fsm_q  <= fsm_d;
            s_q    <= s_d;
            k_q    <= k_d;
            rnd_q  <= rnd_d;
            busy_q <= busy_d;
            done_q <= done_d;
            pt_q   <= pt_d;
            ck_q   <= ck_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign state_out = pt_q;
    assign key_out   = ck_q;

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Bench for aes_inv_cipher: known vectors plus random blocks encrypted by a
// behavioural AES-128 encryptor and decrypted by the DUT.
module tb_aes_inv_cipher;

    logic         clk = 1'b0;
    logic         rst, en;
    logic [127:0] state, key;
    logic         busy, done;
    logic [127:0] state_out, key_out;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sbTab [256];
    logic [127:0] lastPt, lastKey;

    localparam logic [127:0] V1_CT  = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
    localparam logic [127:0] V1_K   = 128'hc5302b4d8ba707f3174a94e37f1d1113;
    localparam logic [127:0] V1_PT  = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] V1_KEY = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] V2_CT  = 128'h320b6a19978511dcfb09dc021d842539;
    localparam logic [127:0] V2_K   = 128'ha60c63b6c80c3fe18925eec9a8f914d0;
    localparam logic [127:0] V2_PT  = 128'h340737e0a29831318d305a88a8f64332;
    localparam logic [127:0] V2_KEY = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
    localparam logic [127:0] LB_PT  = 128'hff6ec9c370a6678992b1fb90f3fd6595;
    localparam logic [127:0] LB_KEY = 128'h01010101010101010101010101010101;

    always #5 clk = ~clk;

    aes_inv_cipher dut (
        .clk(clk), .rst(rst), .en(en), .state(state), .key(key),
        .busy(busy), .done(done), .state_out(state_out), .key_out(key_out)
    );

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    // S-box from its definition: multiplicative inverse (x^254) then affine map.
    function automatic logic [7:0] sboxCalc(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    // Textbook forward cipher with key expansion; also yields the round-10 key.
    task automatic encryptModel(input logic [127:0] pt, input logic [127:0] k0,
                                output logic [127:0] ct, output logic [127:0] k10);
        logic [7:0] st [16];
        logic [7:0] rk [16];
        logic [7:0] tmp [16];
        logic [7:0] t [4];
        logic [7:0] rc;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) begin
            rk[i] = k0[8*i +: 8];
            st[i] = pt[8*i +: 8] ^ rk[i];
        end
        for (int round = 1; round <= 10; round++) begin
            for (int r = 0; r < 4; r++) t[r] = sbTab[rk[12 + ((r + 1) % 4)]];
            t[0] = t[0] ^ rc;
            rc   = gmul(rc, 8'h02);
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    rk[4*c+r] = rk[4*c+r] ^ ((c == 0) ? t[r] : rk[4*(c-1)+r]);
            for (int i = 0; i < 16; i++) st[i] = sbTab[st[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    tmp[4*c+r] = st[4*((c + r) % 4) + r];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    st[4*c+r] = (round < 10)
                        ? gmul(tmp[4*c+r], 8'h02) ^ gmul(tmp[4*c+((r+1)%4)], 8'h03)
                          ^ tmp[4*c+((r+2)%4)] ^ tmp[4*c+((r+3)%4)]
                        : tmp[4*c+r];
            for (int i = 0; i < 16; i++) st[i] = st[i] ^ rk[i];
        end
        for (int i = 0; i < 16; i++) begin
            ct[8*i +: 8]  = st[i];
            k10[8*i +: 8] = rk[i];
        end
    endtask

    // Present inputs for one accepting edge, then scramble them.
    task automatic applyStimulus(input logic [127:0] ct, input logic [127:0] k);
        @(negedge clk);
        state = ct;
        key   = k;
        en    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        en    = 1'b0;
        state = ~ct;
        key   = ~k;
    endtask

    task automatic waitDone(output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 30) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic runOp(input string tag, input logic [127:0] ct, input logic [127:0] k,
                         input logic [127:0] expPt, input logic [127:0] expKey);
        int cycles;
        applyStimulus(ct, k);
        checkOutput({tag, "_busy"}, 128'(busy), 128'd1);
        checkOutput({tag, "_done_low"}, 128'(done), 128'd0);
        checkOutput({tag, "_hold_pt"}, state_out, lastPt);
        checkOutput({tag, "_hold_key"}, key_out, lastKey);
        waitDone(cycles);
        checkOutput({tag, "_latency"}, 128'(cycles), 128'd10);
        checkOutput({tag, "_pt"}, state_out, expPt);
        checkOutput({tag, "_key"}, key_out, expKey);
        checkOutput({tag, "_idle"}, 128'(busy), 128'd0);
        lastPt  = expPt;
        lastKey = expKey;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [127:0] ct, k10, pt, k0;
        int           cycles, highs;
        int           rises [$];
        logic         prevDone;

        rst   = 1'b1;
        en    = 1'b0;
        state = '0;
        key   = '0;
        for (int i = 0; i < 256; i++) sbTab[i] = sboxCalc(8'(i));

        encryptModel(V1_PT, V1_KEY, ct, k10);
        checkOutput("model_c1_ct", ct, V1_CT);
        checkOutput("model_c1_k10", k10, V1_K);

        #3 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_busy", 128'(busy), 128'd0);
        checkOutput("reset_done", 128'(done), 128'd0);
        checkOutput("reset_pt", state_out, 128'd0);
        checkOutput("reset_key", key_out, 128'd0);
        rst     = 1'b1;
        lastPt  = '0;
        lastKey = '0;

        $display("[TB] known-answer vectors");
        runOp("fips_c1", V1_CT, V1_K, V1_PT, V1_KEY);
        runOp("fips_b", V2_CT, V2_K, V2_PT, V2_KEY);

        $display("[TB] en while busy");
        applyStimulus(V1_CT, V1_K);
        cycles = 0;
        while (done !== 1'b1 && cycles < 30) begin
            if (cycles == 3) begin
                state = V2_CT;
                key   = V2_K;
                en    = 1'b1;
            end
            @(negedge clk);
            cycles++;
            en = 1'b0;
            if (done !== 1'b1) checkOutput("ignore_busy", 128'(busy), 128'd1);
        end
        checkOutput("ignore_latency", 128'(cycles), 128'd10);
        checkOutput("ignore_pt", state_out, V1_PT);
        checkOutput("ignore_key", key_out, V1_KEY);
        lastPt  = V1_PT;
        lastKey = V1_KEY;

        $display("[TB] reset mid-operation");
        applyStimulus(V1_CT, V1_K);
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("abort_busy", 128'(busy), 128'd0);
        checkOutput("abort_done", 128'(done), 128'd0);
        checkOutput("abort_pt", state_out, 128'd0);
        checkOutput("abort_key", key_out, 128'd0);
        @(negedge clk);
        rst     = 1'b1;
        lastPt  = '0;
        lastKey = '0;
        runOp("after_abort", V2_CT, V2_K, V2_PT, V2_KEY);

        $display("[TB] en held high");
        @(negedge clk);
        state    = V1_CT;
        key      = V1_K;
        en       = 1'b1;
        highs    = 0;
        prevDone = 1'b0;
        for (int n = 0; n <= 33; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                highs++;
                if (!prevDone) rises.push_back(n);
                checkOutput("cont_pt", state_out, V1_PT);
                checkOutput("cont_key", key_out, V1_KEY);
            end
            prevDone = (done === 1'b1);
        end
        en = 1'b0;
        checkOutput("cont_rise_count", 128'(rises.size()), 128'd3);
        checkOutput("cont_high_cycles", 128'(highs), 128'd3);
        for (int i = 0; i < rises.size() && i < 3; i++)
            checkOutput("cont_rise_time", 128'(rises[i]), 128'(10 + 11 * i));
        waitDone(cycles);
        checkOutput("cont_tail_pt", state_out, V1_PT);
        lastPt  = V1_PT;
        lastKey = V1_KEY;

        $display("[TB] loopback and random blocks");
        encryptModel(LB_PT, LB_KEY, ct, k10);
        runOp("loopback", ct, k10, LB_PT, LB_KEY);
        for (int t = 0; t < 12; t++) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
            k0 = {$urandom, $urandom, $urandom, $urandom};
            encryptModel(pt, k0, ct, k10);
            runOp("random", ct, k10, pt, k0);
            if (t == 0) begin
                repeat (3) @(negedge clk);
                checkOutput("done_hold", 128'(done), 128'd1);
                checkOutput("done_hold_pt", state_out, pt);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
